// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM,
// MEM/WB) carrying a control bundle and a data bundle under valid/ready.
// A two-entry skid buffer (main + skid) lets in_ready be a flop, so a
// downstream stall never forms a combinational path back upstream.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-low reset
//   flush      drop all held beats and any beat offered this cycle
//   in_valid   upstream beat present
//   in_ready   registered; stage accepts a beat this cycle
//   in_ctrl    upstream control bundle   [CTRL_W]
//   in_data    upstream data bundle      [DATA_W]
//   out_valid  head beat present
//   out_ready  downstream takes the head this cycle (0 = stall)
//   out_ctrl   head control, forced to 0 when out_valid==0
//   out_data   head data
//   occupancy  beats held: 0, 1 or 2
module pipe_stage_reg #(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 128,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state_p1;
  logic                in_ready_p1;
  logic [CTRL_W-1:0]   main_ctrl_p1;
  logic [DATA_W-1:0]   main_data_p1;
  logic [CTRL_W-1:0]   skid_ctrl_p1;
  logic [DATA_W-1:0]   skid_data_p1;
  logic                vld_p1;
  logic                xfer_in;
  logic                xfer_out;

  assign vld_p1   = (state_p1 != EMPTY);
  assign xfer_in  = in_valid & in_ready_p1;
  assign xfer_out = vld_p1 & out_ready;

  // Stage boundary: upstream beat -> main/skid storage.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p1     <= EMPTY;
      in_ready_p1  <= 1'b1;
      main_ctrl_p1 <= '0;
      skid_ctrl_p1 <= '0;
      main_data_p1 <= '0;
      skid_data_p1 <= '0;
    end else if (flush) begin
      state_p1     <= EMPTY;
      in_ready_p1  <= 1'b1;
      main_ctrl_p1 <= '0;
      skid_ctrl_p1 <= '0;
      if (CLEAR_DATA) begin
        main_data_p1 <= '0;
        skid_data_p1 <= '0;
      end
    end else begin
      case (state_p1)
        EMPTY: begin
          if (xfer_in) begin
            main_ctrl_p1 <= in_ctrl;
            main_data_p1 <= in_data;
            state_p1     <= ONE;
          end
        end
        ONE: begin
          case ({xfer_in, xfer_out})
            2'b11: begin
              main_ctrl_p1 <= in_ctrl;
              main_data_p1 <= in_data;
            end
            2'b10: begin
              // Head stalled: park the new beat and close the input.
              skid_ctrl_p1 <= in_ctrl;
              skid_data_p1 <= in_data;
              state_p1     <= TWO;
              in_ready_p1  <= 1'b0;
            end
            2'b01: state_p1 <= EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (xfer_out) begin
            main_ctrl_p1 <= skid_ctrl_p1;
            main_data_p1 <= skid_data_p1;
            state_p1     <= ONE;
            in_ready_p1  <= 1'b1;
          end
        end
        default: begin
          state_p1    <= EMPTY;
          in_ready_p1 <= 1'b1;
        end
      endcase
    end
  end

  // Stage boundary: main register -> downstream.
  assign in_ready  = in_ready_p1;
  assign out_valid = vld_p1;
  assign out_ctrl  = vld_p1 ? main_ctrl_p1 : '0;
  assign out_data  = main_data_p1;
  assign occupancy = state_p1;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic          in_ready0, out_valid0, in_ready1, out_valid1;
  logic [CW-1:0] out_ctrl0, out_ctrl1;
  logic [DW-1:0] out_data0, out_data1;
  logic [1:0]    occ0, occ1;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
    .out_data(out_data0), .occupancy(occ0)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
    .out_data(out_data1), .occupancy(occ1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic ordy);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
  endtask

  logic [DW-1:0] sbq[$];
  logic [DW-1:0] seq;
  int            bad_order, bad_ready, bad_occ, n_acc, n_out;

  initial begin
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick(); tick();
    chk("rst_valid", out_valid0, 0);
    chk("rst_occ",   occ0, 0);
    chk("rst_ready", in_ready0, 1);
    chk("rst_ctrl",  out_ctrl0, 0);
    chk("rst_data0", out_data0, 0);
    chk("rst_data1", out_data1, 0);
    rst = 1'b1;

    // streaming at one beat per cycle
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, CW'(8'h10 + i), DW'(i), 1'b1);
      tick();
      chk($sformatf("stream_data%0d", i), out_data0, i);
      chk($sformatf("stream_ctrl%0d", i), out_ctrl0, 8'h10 + i);
      chk($sformatf("stream_occ%0d", i), occ0, 1);
      chk($sformatf("stream_rdy%0d", i), in_ready0, 1);
    end
    drive(1'b0, 8'h77, '0, 1'b1);
    tick();
    chk("drain_valid", out_valid0, 0);
    chk("drain_ctrl",  out_ctrl0, 0);
    chk("drain_occ",   occ0, 0);

    // stall fills the skid entry
    drive(1'b1, 8'h01, 32'd1, 1'b1); tick();
    drive(1'b1, 8'h02, 32'd2, 1'b0); tick();
    chk("skid_occ",   occ0, 2);
    chk("skid_ready", in_ready0, 0);
    chk("skid_head",  out_data0, 1);
    drive(1'b1, 8'h03, 32'd3, 1'b0); tick();
    chk("stall_head", out_data0, 1);
    chk("stall_occ",  occ0, 2);
    drive(1'b1, 8'h03, 32'd3, 1'b1); tick();
    chk("rel_head",  out_data0, 2);
    chk("rel_occ",   occ0, 1);
    chk("rel_ready", in_ready0, 1);
    tick();
    chk("rel_head3", out_data0, 3);
    chk("rel_ctrl3", out_ctrl0, 8'h03);
    drive(1'b0, '0, '0, 1'b1); tick();
    chk("rel_empty", occ0, 0);

    // flush while full, with a beat offered on the same edge
    drive(1'b1, 8'hFF, 32'hDEAD_BEEF, 1'b0); tick();
    drive(1'b1, 8'hFF, 32'h0000_000B, 1'b0); tick();
    chk("fl_pre_occ",  occ0, 2);
    chk("fl_pre_ctrl", out_ctrl0, 8'hFF);
    flush = 1'b1;
    drive(1'b1, 8'hFF, 32'h0000_000C, 1'b0); tick();
    flush = 1'b0;
    chk("fl_valid",  out_valid0, 0);
    chk("fl_ctrl",   out_ctrl0, 0);
    chk("fl_occ",    occ0, 0);
    chk("fl_ready",  in_ready0, 1);
    chk("fl_stale",  out_data0, 32'hDEAD_BEEF);
    chk("fl_clear",  out_data1, 0);
    chk("fl_ctrl1",  out_ctrl1, 0);
    drive(1'b0, '0, '0, 1'b1); tick();
    chk("fl_noC", out_valid0, 0);

    // reset while holding two beats
    drive(1'b1, 8'h21, 32'h21, 1'b0); tick();
    drive(1'b1, 8'h22, 32'h22, 1'b0); tick();
    chk("rm_pre_occ", occ0, 2);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0); tick();
    rst = 1'b1;
    chk("rm_valid", out_valid0, 0);
    chk("rm_occ",   occ0, 0);
    chk("rm_ready", in_ready0, 1);
    chk("rm_ctrl",  out_ctrl0, 0);
    chk("rm_data",  out_data0, 0);
    drive(1'b1, 8'h05, 32'h33, 1'b1); tick();
    chk("rm_post_valid", out_valid0, 1);
    chk("rm_post_data",  out_data0, 32'h33);
    drive(1'b0, '0, '0, 1'b1); tick();
    chk("rm_post_empty", occ0, 0);

    // random back-pressure against a FIFO scoreboard
    seq = 32'h100; bad_order = 0; bad_ready = 0; bad_occ = 0; n_acc = 0; n_out = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      drive(1'($urandom_range(0, 3) != 0), seq[CW-1:0], seq, 1'($urandom_range(0, 1)));
      if (occ0 == 2 && in_ready0) bad_ready++;
      if (int'(occ0) != sbq.size()) bad_occ++;
      if (out_valid0 && out_ready) begin
        if (sbq.size() == 0 || out_data0 !== sbq[0] || out_ctrl0 !== sbq[0][CW-1:0])
          bad_order++;
        if (sbq.size() != 0) void'(sbq.pop_front());
        n_out++;
      end
      if (in_valid && in_ready0) begin
        sbq.push_back(seq);
        seq++;
        n_acc++;
      end
      tick();
    end
    chk("rand_order", bad_order, 0);
    chk("rand_ready", bad_ready, 0);
    chk("rand_occ",   bad_occ, 0);
    chk("rand_flow",  n_out + sbq.size(), n_acc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
